// File: rtl/core_pkg.sv
// Shared definitions for the core partial-sum path: array geometry defaults
// and the one-hot issue FSM encoding.
package core_pkg;

   localparam int unsigned ARR_IDATA_BIT = 8;
   localparam int unsigned ARR_MAC_NUM   = 16;
   localparam int unsigned ARR_CDATA_BIT = 8;

   // A full MAC-array sum: product width plus carry growth over all MACs.
   localparam int unsigned PSUM_DATA_BIT = ARR_IDATA_BIT*2 + $clog2(ARR_MAC_NUM);

   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_RUN  = 4'b0010,
      S_GAP  = 4'b0100,
      S_DONE = 4'b1000
   } psum_state_e;

endpackage

// File: rtl/core_psum_fifo.sv
// Input buffer for partial sums; the read port is combinational so the issuer
// owns the output register.
module core_psum_fifo
   import core_pkg::*;
#(
   parameter int unsigned DATA_BIT   = PSUM_DATA_BIT,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                push,
   input  logic [DATA_BIT-1:0] wr_data,
   input  logic                pop,
   output logic [DATA_BIT-1:0] rd_data_c,
   output logic                full_c,
   output logic                empty_c
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [AW:0]         wr_ptr;
   logic [AW:0]         rd_ptr;
   logic [DATA_BIT-1:0] mem [FIFO_DEPTH];

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty_c   = (wr_ptr == rd_ptr);
   assign rd_data_c = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full_c) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty_c) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full_c) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/core_psum_issue.sv
// Partial-sum transmitter: buffers MAC-array sums and re-issues them to the
// accumulator as groups of acc_num beats separated by GROUP_GAP idle cycles.
module core_psum_issue
   import core_pkg::*;
#(
   parameter int unsigned DATA_BIT   = PSUM_DATA_BIT,
   parameter int unsigned CDATA_BIT  = ARR_CDATA_BIT,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned GROUP_GAP  = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [CDATA_BIT-1:0] cfg_acc_num,
   input  logic [CDATA_BIT-1:0] cfg_grp_num,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   input  logic [DATA_BIT-1:0]  in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DATA_BIT-1:0]  psum_data,
   output logic                 psum_valid,
   output logic                 psum_last
);

   localparam int unsigned TOT_W = 2*CDATA_BIT;
   localparam int unsigned GAP_W = (GROUP_GAP > 1) ? $clog2(GROUP_GAP) : 1;

   psum_state_e          state;
   logic [CDATA_BIT-1:0] acc_num;
   logic [CDATA_BIT-1:0] grp_num;
   logic [CDATA_BIT-1:0] beat_cnt;
   logic [CDATA_BIT-1:0] grp_cnt;
   logic [GAP_W-1:0]     gap_cnt;
   logic [TOT_W-1:0]     acc_cnt;
   logic [TOT_W-1:0]     total_c;
   logic [DATA_BIT-1:0]  rd_data_c;
   logic                 full_c;
   logic                 empty_c;
   logic                 push_c;
   logic                 pop_c;
   logic                 last_beat_c;
   logic                 last_grp_c;

   // Acceptance stops at the job total so stray beats never reach the FIFO.
   assign total_c     = TOT_W'(acc_num) * TOT_W'(grp_num);
   assign in_ready    = busy && !full_c && (acc_cnt < total_c);
   assign push_c      = in_valid && in_ready;
   assign pop_c       = (state == S_RUN) && !empty_c;
   assign last_beat_c = (beat_cnt == acc_num - CDATA_BIT'(1));
   assign last_grp_c  = (grp_cnt == grp_num - CDATA_BIT'(1));

   core_psum_fifo #(
      .DATA_BIT   (DATA_BIT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push_c),
      .wr_data   (in_data),
      .pop       (pop_c),
      .rd_data_c (rd_data_c),
      .full_c    (full_c),
      .empty_c   (empty_c)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         acc_num    <= '0;
         grp_num    <= '0;
         beat_cnt   <= '0;
         grp_cnt    <= '0;
         gap_cnt    <= '0;
         acc_cnt    <= '0;
         psum_data  <= '0;
         psum_valid <= 1'b0;
         psum_last  <= 1'b0;
      end else begin
         psum_valid <= 1'b0;
         psum_last  <= 1'b0;
         done       <= 1'b0;
         if (push_c) acc_cnt <= acc_cnt + TOT_W'(1);

         unique case (state)
            // A start coinciding with the done pulse belongs to the old job.
            S_IDLE: begin
               if (start && !done) begin
                  acc_num  <= (cfg_acc_num == '0) ? CDATA_BIT'(1) : cfg_acc_num;
                  grp_num  <= cfg_grp_num;
                  beat_cnt <= '0;
                  grp_cnt  <= '0;
                  gap_cnt  <= '0;
                  acc_cnt  <= '0;
                  busy     <= 1'b1;
                  state    <= (cfg_grp_num == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (pop_c) begin
                  psum_data  <= rd_data_c;
                  psum_valid <= 1'b1;
                  if (last_beat_c) begin
                     psum_last <= 1'b1;
                     beat_cnt  <= '0;
                     grp_cnt   <= grp_cnt + CDATA_BIT'(1);
                     if (last_grp_c)         state <= S_DONE;
                     else if (GROUP_GAP > 0) state <= S_GAP;
                  end else begin
                     beat_cnt <= beat_cnt + CDATA_BIT'(1);
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_W'(GROUP_GAP - 1)) begin
                  gap_cnt <= '0;
                  state   <= S_RUN;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/core_psum_issue.md
# core_psum_issue

Transmitter side of the partial-sum stream consumed by the accumulation block. Accepts partial sums from the MAC array over a valid/ready handshake and buffers them in a small FIFO. Re-issues them as a gap-controlled `psum_valid` stream framed into groups of `cfg_acc_num` beats. Runs one job of `cfg_grp_num` groups per `start` and reports completion.

## Interface
- `DATA_BIT`, default `` `ARR_IDATA_BIT*2+$clog2(`ARR_MAC_NUM) ``: partial-sum width.
- `CDATA_BIT`, default `` `ARR_CDATA_BIT ``: config width.
- `FIFO_DEPTH`, default 4: input buffer entries; must be a power of 2 and ≥ 2.
- `GROUP_GAP`, default 1: idle output cycles inserted after each group's last beat; 0 is allowed.

- `clk` in 1: clock.
- `rstn` in 1: reset; asynchronous, active-low.
- `cfg_acc_num` in CDATA_BIT: beats per group. Sampled at `start`; a value of 0 is treated as 1.
- `cfg_grp_num` in CDATA_BIT: groups per job. Sampled at `start`.
- `start` in 1: job start pulse. Ignored while `busy`.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle completion pulse.
- `in_data` in DATA_BIT: partial sum from the MAC array.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: block accepts `in_data`.
- `psum_data` out DATA_BIT: issued partial sum.
- `psum_valid` out 1: issue strobe. The downstream always accepts; there is no backpressure.
- `psum_last` out 1: marks the final beat of a group; qualified by `psum_valid`.

## Operation
- **Reset values.** All outputs are 0: `busy`, `done`, `in_ready`, `psum_*`. The FIFO is empty and all counters are 0.
- **FSM states:** IDLE, RUN, GAP, DONE.
  - IDLE → RUN on `start`. At that edge the block latches `acc_num = max(cfg_acc_num, 1)` and `grp_num = cfg_grp_num`, and clears the counters.
  - IDLE → DONE directly if `grp_num` == 0. No beats are issued.
  - RUN: pops one FIFO entry per cycle when the FIFO is non-empty and registers it to `psum_*`. `beat_cnt` increments per pop.
    - On the pop where `beat_cnt` == `acc_num-1`: `psum_last`=1, `beat_cnt` returns to 0, `grp_cnt` increments.
    - If that was the last group, go to DONE. Otherwise go to GAP when `GROUP_GAP` > 0, or stay in RUN when `GROUP_GAP` = 0.
  - GAP: `gap_cnt` counts `GROUP_GAP` cycles with no pop, then returns to RUN. The FIFO may still fill during GAP.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy` = (state != IDLE).
- **Input acceptance:** `in_ready` = `busy` && !`fifo_full` && (`acc_cnt` < `acc_num*grp_num`).
  - `acc_cnt` counts accepted beats and is sized 2*CDATA_BIT.
  - Beats beyond the job total are never accepted. `in_ready` does not depend on a same-cycle pop.
- **Output cycles:** in cycles with no pop, `psum_valid`=0 and `psum_last`=0. `psum_data` holds its last value.
- **Widths:** data passes through unmodified; there is no arithmetic on data.
- **Simultaneous push and pop:** allowed when the FIFO is non-full. Occupancy stays unchanged.
- **Empty FIFO in RUN:** no issue occurs; the state and counters hold.
- **`start` while busy:** ignored; the config is not re-sampled.
- **Reset mid-job:** immediately returns to IDLE and discards the FIFO contents. No `done` is generated.

## Timing
- **Latency:** a beat accepted at edge E is popped at the earliest at edge E+1. `psum_valid` is high in the cycle after edge E+1, giving a minimum of 1 cycle through an empty FIFO.
- **Throughput:** 1 beat/cycle within a group.
- **Group spacing:** exactly `GROUP_GAP` idle cycles between the last beat of one group and the first beat of the next, provided data is available.
- **`done`:** asserted in the cycle after the final `psum_last`.
- **Back-to-back jobs:** a `start` during the `done` cycle is ignored. The earliest accepted restart is the next cycle, while in IDLE.
- **Inputs:** all inputs are sampled synchronously on `clk`.

## Structure
- **Shared package `core_pkg`:** FSM state encoding (IDLE/RUN/GAP/DONE, one-hot 4-bit) and the default `DATA_BIT` expression.
- **Sub-module `core_psum_fifo`:** synchronous FIFO with `DATA_BIT`/`FIFO_DEPTH` parameters and full/empty flags. Pointers are log2(DEPTH)+1 bits for wrap detection. It provides a registered-free read port; the output registering lives in the top level.
- **Top level:** FSM, `beat_cnt`/`grp_cnt`/`gap_cnt`/`acc_cnt`, output registers.

## Test plan
- **Basic stream:** `acc_num`=4, `grp_num`=2, `GROUP_GAP`=1, continuous `in_valid` with values 1..8 → `psum_data` 1,2,3,4, one idle cycle, 5,6,7,8. `psum_last` on 4 and 8; `done` one cycle after beat 8; exactly 8 beats accepted.
- **Backpressure:** hold the FIFO input while GAP runs, with `GROUP_GAP`=3 and DEPTH=4 → `in_ready` drops when 4 entries are stored. No beat is lost or duplicated; order is preserved.
- **Job total cap:** `acc_num`=3, `grp_num`=1, `in_valid` held high for 10 cycles → only 3 beats accepted and `in_ready`=0 afterwards. Output is 3 beats with `psum_last` on the third.
- **Degenerate config:** `cfg_acc_num`=0 with `grp_num`=2 → each beat is its own group with `psum_last`=1. Separately, `cfg_grp_num`=0 → `done` pulses 2 cycles after `start` with no `psum_valid`.
- **Starved input:** `acc_num`=4 with beats arriving every 3rd cycle → `psum_valid` is sparse and `psum_last` lands only on the 4th beat. The counters do not advance on empty cycles.
- **Reset mid-job:** assert `rstn`=0 after 2 of 4 beats issue → all outputs are 0 within the reset. A new job afterwards starts with `beat_cnt`=0, and its first `psum_last` comes after 4 fresh beats.
